proc_out_uart: RTL and testbench

PROC_OUT_UART -- requirements
Module: proc_out_uart

---
 rtl/proc_out_uart.sv | 217 +++++++++++++++++++++
 tb/tb_proc_out_uart.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_out_uart.sv
// proc_out_uart: queues every change of the processor out0 register and sends each word as four
// back-to-back UART frames, low byte first. Define PROC_OUT_UART_PARITY_EN to add an even parity bit.
//
// state  | meaning
// IDLE   | line high; pops the head word when the FIFO is non-empty
// START  | start bit, line low
// DATA   | 8 data bits of the current byte, LSB first
// PARITY | even parity of the current byte (PROC_OUT_UART_PARITY_EN builds only)
// STOP   | stop bit, line high; then the next byte or back to IDLE
module proc_out_uart #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 out0,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PROC_OUT_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      prev_q, prev_d;
  logic [31:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [TMR_W-1:0] timer_q, timer_d;
`ifdef PROC_OUT_UART_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic push_req;
  logic push_ok;
  logic pop;
  logic full;
  logic bit_done;

  // Change detect and word FIFO bookkeeping
  always_comb begin
    push_req   = (out0 != prev_q);
    prev_d     = out0;
    full       = (count_q == CNT_FULL);
    pop        = (state_q == S_IDLE) && (count_q != '0);
    // a pop on the same edge frees the slot, so a full FIFO still accepts the word
    push_ok    = push_req && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & ~push_ok);
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    timer_d    = timer_q;
`ifdef PROC_OUT_UART_PARITY_EN
    parity_d   = parity_q;
`endif
    tx         = 1'b1;
    bit_done   = (timer_q == TMR_LAST);
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pop) begin
          shift_d    = fifo_mem_q[rd_ptr_q];
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        tx = 1'b0;
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
`ifdef PROC_OUT_UART_PARITY_EN
          parity_d  = 1'b0;
`endif
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        // the word shifts right one bit per data bit, so the next byte lands at bit 0
        tx = shift_q[0];
        if (bit_done) begin
          timer_d  = '0;
          shift_d  = {1'b0, shift_q[31:1]};
`ifdef PROC_OUT_UART_PARITY_EN
          parity_d = parity_q ^ shift_q[0];
`endif
          if (bit_idx_q == 3'd7) begin
`ifdef PROC_OUT_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef PROC_OUT_UART_PARITY_EN
      S_PARITY: begin
        tx = parity_q;
        if (bit_done) begin
          timer_d = '0;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx = 1'b1;
        if (bit_done) begin
          timer_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      timer_q    <= '0;
`ifdef PROC_OUT_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
`ifdef PROC_OUT_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Storage is not reset; the pointers and count define which entries are valid
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      fifo_mem_q[wr_ptr_q] <= out0;
    end
  end

  assign busy       = (count_q != '0) || (state_q != S_IDLE);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_proc_out_uart.sv
// tb_proc_out_uart: directed bench for proc_out_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours PROC_OUT_UART_PARITY_EN for the frame length and the parity scenario.
module tb_proc_out_uart;

  localparam int CPB = 4;
`ifdef PROC_OUT_UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int WORD_CYC = 4 * FL * CPB;
  localparam int WORD_PER = WORD_CYC + 1;
  localparam int LOG_N    = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] out0;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic        tx_log   [LOG_N];
  logic        busy_log [LOG_N];
  logic [2:0]  cnt_log  [LOG_N];
  logic        ovf_log  [LOG_N];

  int          stim_idx [8];
  logic [31:0] stim_val [8];
  int          n_stim;
  int          rst_on;
  int          rst_off;

  proc_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .out0       (out0),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log index i is sampled at a falling edge; stimulus set there acts on the following rising edge.
  task automatic run_capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i]   = tx;
      busy_log[i] = busy;
      cnt_log[i]  = fifo_count;
      ovf_log[i]  = overflow;
      for (int s = 0; s < n_stim; s++) begin
        if (stim_idx[s] == i) out0 = stim_val[s];
      end
      if (i == rst_on)  rst = 1'b1;
      if (i == rst_off) rst = 1'b0;
    end
  endtask

  task automatic clear_stim();
    n_stim  = 0;
    rst_on  = -1;
    rst_off = -1;
  endtask

  task automatic add_stim(input int idx, input logic [31:0] val);
    stim_idx[n_stim] = idx;
    stim_val[n_stim] = val;
    n_stim++;
  endtask

  function automatic logic [10:0] obs_frame(input int base);
    logic [10:0] f;
    f = '0;
    for (int b = 0; b < FL; b++) f[b] = tx_log[base + b * CPB + CPB / 2];
    return f;
  endfunction

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '0;
    f[8:1] = d;
`ifdef PROC_OUT_UART_PARITY_EN
    f[9]  = ^d;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    out0 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] w;
    int run;
    w = 32'h0000_00A5;
    clear_stim();
    add_stim(0, w);
    run_capture(200);
    n_cmp++; if (cnt_log[1] !== 3'd1) begin n_err++; $display("FAIL single_enq_count: got %0d want 1", cnt_log[1]); end
    n_cmp++; if (busy_log[1] !== 1'b1) begin n_err++; $display("FAIL single_pop_busy: got %b want 1", busy_log[1]); end
    n_cmp++; if (tx_log[1] !== 1'b1) begin n_err++; $display("FAIL single_pop_tx: got %b want 1", tx_log[1]); end
    n_cmp++; if (tx_log[2] !== 1'b0) begin n_err++; $display("FAIL single_first_low: got %b want 0", tx_log[2]); end
    n_cmp++; if (cnt_log[2] !== 3'd0) begin n_err++; $display("FAIL single_post_pop_count: got %0d want 0", cnt_log[2]); end
    for (int f = 0; f < 4; f++) begin
      n_cmp++;
      if (obs_frame(2 + f * FL * CPB) !== exp_frame(w[f*8 +: 8])) begin
        n_err++;
        $display("FAIL single_frame%0d: got %h want %h", f, obs_frame(2 + f * FL * CPB), exp_frame(w[f*8 +: 8]));
      end
    end
    run = 0;
    while (run + 2 < 200 && busy_log[run + 2] === 1'b1) run++;
    n_cmp++; if (run !== WORD_CYC) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", run, WORD_CYC); end
  endtask

  task automatic test_hold();
    logic [31:0] w;
    int max_cnt;
    int lows;
    w = 32'h1234_5678;
    clear_stim();
    add_stim(0, w);
    run_capture(500);
    for (int f = 0; f < 4; f++) begin
      n_cmp++;
      if (obs_frame(2 + f * FL * CPB) !== exp_frame(w[f*8 +: 8])) begin
        n_err++;
        $display("FAIL hold_frame%0d: got %h want %h", f, obs_frame(2 + f * FL * CPB), exp_frame(w[f*8 +: 8]));
      end
    end
    max_cnt = 0;
    lows    = 0;
    for (int i = 0; i < 500; i++) begin
      if (int'(cnt_log[i]) > max_cnt) max_cnt = int'(cnt_log[i]);
      if (i >= 2 + WORD_CYC && tx_log[i] !== 1'b1) lows++;
    end
    n_cmp++; if (max_cnt !== 1) begin n_err++; $display("FAIL hold_peak_count: got %0d want 1", max_cnt); end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL hold_extra_tx: got %0d low samples want 0", lows); end
  endtask

  task automatic test_overflow();
    int last_idle;
    clear_stim();
    for (int k = 0; k < 6; k++) add_stim(k, 32'(k + 1));
    run_capture(820);
    n_cmp++; if (cnt_log[5] !== 3'd4) begin n_err++; $display("FAIL ovf_full_count: got %0d want 4", cnt_log[5]); end
    n_cmp++; if (ovf_log[5] !== 1'b0) begin n_err++; $display("FAIL ovf_before_drop: got %b want 0", ovf_log[5]); end
    n_cmp++; if (cnt_log[6] !== 3'd4) begin n_err++; $display("FAIL ovf_drop_count: got %0d want 4", cnt_log[6]); end
    n_cmp++; if (ovf_log[6] !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf_log[6]); end
    for (int k = 0; k < 5; k++) begin
      for (int f = 0; f < 4; f++) begin
        n_cmp++;
        if (obs_frame(2 + k * WORD_PER + f * FL * CPB) !== exp_frame((f == 0) ? 8'(k + 1) : 8'h00)) begin
          n_err++;
          $display("FAIL ovf_word%0d_frame%0d: got %h want %h", k, f,
                   obs_frame(2 + k * WORD_PER + f * FL * CPB), exp_frame((f == 0) ? 8'(k + 1) : 8'h00));
        end
      end
    end
    last_idle = 2 + 4 * WORD_PER + WORD_CYC;
    n_cmp++; if (busy_log[last_idle] !== 1'b0) begin n_err++; $display("FAIL ovf_end_busy: got %b want 0", busy_log[last_idle]); end
    n_cmp++; if (tx_log[last_idle + 5] !== 1'b1) begin n_err++; $display("FAIL ovf_no_word6: got %b want 1", tx_log[last_idle + 5]); end
    n_cmp++; if (ovf_log[last_idle] !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf_log[last_idle]); end
  endtask

  task automatic test_reset_abort();
    int lows;
    int busys;
    clear_stim();
    add_stim(0, 32'd1);
    add_stim(1, 32'd2);
    add_stim(2, 32'd3);
    add_stim(100, 32'd0);
    rst_on  = 100;
    rst_off = 101;
    run_capture(400);
    n_cmp++; if (cnt_log[100] !== 3'd2) begin n_err++; $display("FAIL abort_queued: got %0d want 2", cnt_log[100]); end
    n_cmp++; if (tx_log[100] !== 1'b0) begin n_err++; $display("FAIL abort_mid_data_tx: got %b want 0", tx_log[100]); end
    n_cmp++; if (tx_log[101] !== 1'b1) begin n_err++; $display("FAIL abort_tx: got %b want 1", tx_log[101]); end
    n_cmp++; if (cnt_log[101] !== 3'd0) begin n_err++; $display("FAIL abort_count: got %0d want 0", cnt_log[101]); end
    n_cmp++; if (busy_log[101] !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_log[101]); end
    n_cmp++; if (ovf_log[101] !== 1'b0) begin n_err++; $display("FAIL abort_overflow: got %b want 0", ovf_log[101]); end
    lows  = 0;
    busys = 0;
    for (int i = 101; i < 400; i++) begin
      if (tx_log[i] !== 1'b1) lows++;
      if (busy_log[i] !== 1'b0) busys++;
    end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL abort_no_frames: got %0d low samples want 0", lows); end
    n_cmp++; if (busys !== 0) begin n_err++; $display("FAIL abort_stays_idle: got %0d busy samples want 0", busys); end
  endtask

  task automatic test_full_pop_edge();
    clear_stim();
    for (int k = 0; k < 5; k++) add_stim(k, 32'(k + 1));
    add_stim(2 + WORD_CYC, 32'd7);
    run_capture(1000);
    n_cmp++; if (cnt_log[2 + WORD_CYC] !== 3'd4) begin n_err++; $display("FAIL fullpop_pre_count: got %0d want 4", cnt_log[2 + WORD_CYC]); end
    n_cmp++; if (tx_log[2 + WORD_CYC] !== 1'b1) begin n_err++; $display("FAIL fullpop_idle_tx: got %b want 1", tx_log[2 + WORD_CYC]); end
    n_cmp++; if (cnt_log[3 + WORD_CYC] !== 3'd4) begin n_err++; $display("FAIL fullpop_count: got %0d want 4", cnt_log[3 + WORD_CYC]); end
    n_cmp++; if (ovf_log[3 + WORD_CYC] !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b want 0", ovf_log[3 + WORD_CYC]); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (obs_frame(2 + k * WORD_PER) !== exp_frame((k < 5) ? 8'(k + 1) : 8'h07)) begin
        n_err++;
        $display("FAIL fullpop_word%0d_byte0: got %h want %h", k, obs_frame(2 + k * WORD_PER),
                 exp_frame((k < 5) ? 8'(k + 1) : 8'h07));
      end
    end
  endtask

  task automatic test_reset_priority();
    rst  = 1'b1;
    out0 = 32'h0000_0055;
    repeat (3) @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rstprio_count: got %0d want 0", fifo_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstprio_busy: got %b want 0", busy); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL rstprio_enq_after: got %0d want 1", fifo_count); end
    rst  = 1'b1;
    out0 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef PROC_OUT_UART_PARITY_EN
  task automatic test_parity();
    int run;
    clear_stim();
    add_stim(0, 32'h0000_0007);
    run_capture(220);
    n_cmp++; if (obs_frame(2) !== 11'h60E) begin n_err++; $display("FAIL parity_frame0: got %h want 60e", obs_frame(2)); end
    for (int f = 1; f < 4; f++) begin
      n_cmp++;
      if (obs_frame(2 + f * FL * CPB) !== 11'h400) begin
        n_err++;
        $display("FAIL parity_frame%0d: got %h want 400", f, obs_frame(2 + f * FL * CPB));
      end
    end
    run = 0;
    while (run + 2 < 220 && busy_log[run + 2] === 1'b1) run++;
    n_cmp++; if (run !== 176) begin n_err++; $display("FAIL parity_word_len: got %0d want 176", run); end
  endtask
`endif

  initial begin
    rst  = 1'b1;
    out0 = '0;
    clear_stim();
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_reset_abort();
    test_full_pop_edge();
    test_reset_priority();
`ifdef PROC_OUT_UART_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
